// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
package vend_pkg;

  localparam int MONEY_W = 8;

  typedef logic [MONEY_W-1:0] money_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_VEND    = 3'd2,
    S_SETTLE  = 3'd3,
    S_CHANGE  = 3'd4
  } vend_state_t;

endpackage

// File: rtl/vend_controller.sv
// Sequencing FSM for the vending machine credit accumulator: accepts coins,
// checks selections against the price table, runs the dispenser handshake
// and then the change-return handshake with the coin hopper.
module vend_controller
  import vend_pkg::*;
#(
  parameter money_t PRICE0     = 8'd50,
  parameter money_t PRICE1     = 8'd75,
  parameter money_t PRICE2     = 8'd100,
  parameter money_t PRICE3     = 8'd125,
  parameter money_t MAX_CREDIT = 8'd250,
  parameter int     TIMEOUT    = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         coin_valid,
  input  logic [7:0]   coin_value,
  input  logic         sel_valid,
  input  logic [1:0]   sel_item,
  input  logic         cancel,
  input  logic [7:0]   acc_total,
  output logic         acc_ld,
  output logic [7:0]   acc_d,
  output logic         acc_update,
  output logic [7:0]   acc_remaining,
  output logic         vend_req,
  output logic [1:0]   vend_item,
  input  logic         vend_ack,
  output logic         change_valid,
  output logic [7:0]   change_amount,
  input  logic         change_ack,
  output logic         coin_reject,
  output logic         insufficient
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  vend_state_t       state_q, state_d;
  logic [1:0]        item_q, item_d;
  money_t            amount_q, amount_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  money_t            price;
  logic [MONEY_W:0]  credit_sum;
  logic              coin_fits;
  logic              no_event;
  logic              timeout_hit;

  // State and transaction registers; reset abandons any open handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      item_q   <= 2'd0;
      amount_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      item_q   <= item_d;
      amount_q <= amount_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next-state and output decode; priority cancel > selection > coin.
  always_comb begin
    state_d       = state_q;
    item_d        = item_q;
    amount_d      = amount_q;
    tmo_d         = tmo_q;
    acc_ld        = 1'b0;
    acc_d         = '0;
    acc_update    = 1'b0;
    acc_remaining = '0;
    vend_req      = 1'b0;
    vend_item     = 2'd0;
    change_valid  = 1'b0;
    change_amount = '0;
    coin_reject   = 1'b0;
    insufficient  = 1'b0;

    unique case (sel_item)
      2'd0:    price = PRICE0;
      2'd1:    price = PRICE1;
      2'd2:    price = PRICE2;
      default: price = PRICE3;
    endcase

    // 9-bit sum so a coin that would overflow the 8-bit total is rejected.
    credit_sum  = {1'b0, acc_total} + {1'b0, coin_value};
    coin_fits   = (credit_sum <= {1'b0, MAX_CREDIT});
    no_event    = !cancel && !sel_valid && !coin_valid;
    // The TIMEOUT-th consecutive idle cycle in COLLECT behaves as a cancel.
    timeout_hit = (state_q == S_COLLECT) && no_event &&
                  (tmo_q == TMO_W'(TIMEOUT - 1));

    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (cancel || timeout_hit) begin
          coin_reject = coin_valid;
          if (acc_total != '0) begin
            amount_d = acc_total;
            state_d  = S_CHANGE;
          end else begin
            state_d  = S_IDLE;
          end
        end else if (sel_valid) begin
          coin_reject = coin_valid;
          if (acc_total >= price) begin
            item_d   = sel_item;
            amount_d = acc_total - price;
            state_d  = S_VEND;
          end else begin
            insufficient = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_fits) begin
            acc_ld  = 1'b1;
            acc_d   = coin_value;
            tmo_d   = '0;
            state_d = S_COLLECT;
          end else begin
            coin_reject = 1'b1;
          end
        end else if (state_q == S_COLLECT) begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_VEND: begin
        vend_req    = 1'b1;
        vend_item   = item_q;
        coin_reject = coin_valid;
        if (vend_ack) state_d = S_SETTLE;
      end

      S_SETTLE: begin
        acc_update    = 1'b1;
        acc_remaining = amount_q;
        coin_reject   = coin_valid;
        state_d       = (amount_q != '0) ? S_CHANGE : S_IDLE;
      end

      S_CHANGE: begin
        change_valid  = 1'b1;
        change_amount = amount_q;
        coin_reject   = coin_valid;
        if (change_ack) begin
          acc_update    = 1'b1;
          acc_remaining = '0;
          state_d       = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs stay quiet while reset is held.
    if (reset) begin
      acc_ld        = 1'b0;
      acc_d         = '0;
      acc_update    = 1'b0;
      acc_remaining = '0;
      vend_req      = 1'b0;
      vend_item     = 2'd0;
      change_valid  = 1'b0;
      change_amount = '0;
      coin_reject   = 1'b0;
      insufficient  = 1'b0;
    end
  end

endmodule
